// File: rtl/word_uart_tx.sv
// -----------------------------------------------------------------------------
// word_uart_tx
// Serialises a 16-bit word as two back-to-back 8N1 frames, low byte first.
// Each start, data and stop bit is held for CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   data_in        word to transmit
//   data_in_valid  load strobe; accepted only while idle
//   tx             serial line, idles high
//   tx_done        one-cycle pulse in the first idle cycle after a word
//   tx_busy        high while a word is on the line
//   overrun        sticky; a new load strobe arrived while busy
// -----------------------------------------------------------------------------
module word_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        data_in_valid,
    output logic        tx,
    output logic        tx_done,
    output logic        tx_busy,
    output logic        overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [2:0]     bit_idx_r, bit_idx_s;
    logic           byte_idx_r, byte_idx_s;
    logic [15:0]    shreg_r, shreg_s;
    logic           tx_r, tx_s;
    logic           tx_done_r, tx_done_s;
    logic           tx_busy_r, tx_busy_s;
    logic           overrun_r, overrun_s;
    logic           valid_d_r;
    logic           bit_end_s;
    logic           strobe_s;

    assign bit_end_s = (cnt_r == CNT_MAX);
    // A held-high valid is one request: only its rising edge can flag an
    // overrun, while acceptance itself is level-based in IDLE so a held valid
    // reloads in the tx_done cycle.
    assign strobe_s  = data_in_valid & ~valid_d_r;

    assign tx      = tx_r;
    assign tx_done = tx_done_r;
    assign tx_busy = tx_busy_r;
    assign overrun = overrun_r;

    // State, datapath and registered output storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 1'b0;
            shreg_r    <= 16'h0000;
            tx_r       <= 1'b1;
            tx_done_r  <= 1'b0;
            tx_busy_r  <= 1'b0;
            overrun_r  <= 1'b0;
            valid_d_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bit_idx_r  <= bit_idx_s;
            byte_idx_r <= byte_idx_s;
            shreg_r    <= shreg_s;
            tx_r       <= tx_s;
            tx_done_r  <= tx_done_s;
            tx_busy_r  <= tx_busy_s;
            overrun_r  <= overrun_s;
            valid_d_r  <= data_in_valid;
        end
    end

    // Next-state, bit-period counter, bit/byte indices and shift register.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_idx_s  = bit_idx_r;
        byte_idx_s = byte_idx_r;
        shreg_s    = shreg_r;
        case (state_r)
            ST_IDLE: begin
                if (data_in_valid) begin
                    state_s    = ST_START;
                    shreg_s    = data_in;
                    cnt_s      = '0;
                    bit_idx_s  = 3'd0;
                    byte_idx_s = 1'b0;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_s     = '0;
                    // Shift after every data bit; after eight shifts the high
                    // byte sits in bits [7:0] ready for the second frame.
                    shreg_s   = {1'b0, shreg_r[15:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_s = '0;
                    if (byte_idx_r == 1'b0) begin
                        state_s    = ST_START;
                        byte_idx_s = 1'b1;
                    end else begin
                        state_s    = ST_IDLE;
                        byte_idx_s = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                cnt_s      = '0;
                bit_idx_s  = 3'd0;
                byte_idx_s = 1'b0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // line changes in the same cycle the state does.
    always_comb begin
        tx_s      = 1'b1;
        tx_done_s = 1'b0;
        tx_busy_s = 1'b0;
        overrun_s = overrun_r;
        case (state_s)
            ST_IDLE:  tx_s = 1'b1;
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shreg_s[0];
            ST_STOP:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
        if (state_s != ST_IDLE) begin
            tx_busy_s = 1'b1;
        end else begin
            tx_busy_s = 1'b0;
        end
        if ((state_r == ST_STOP) && (byte_idx_r == 1'b1) && bit_end_s) begin
            tx_done_s = 1'b1;
        end else begin
            tx_done_s = 1'b0;
        end
        if (strobe_s && (state_r != ST_IDLE)) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end
    end

endmodule

// File: tb/tb_word_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_word_uart_tx
// Scoreboard bench: the stimulus pushes every word it expects on the line;
// an independent UART receiver model decodes tx at mid-bit and compares.
// -----------------------------------------------------------------------------
module tb_word_uart_tx;

    localparam int C = 4;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        data_in_valid;
    logic        tx;
    logic        tx_done;
    logic        tx_busy;
    logic        overrun;

    int          checks    = 0;
    int          errors    = 0;
    int          exp_done  = 0;
    int          done_seen = 0;
    logic [15:0] exp_q[$];

    word_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .tx            (tx),
        .tx_done       (tx_done),
        .tx_busy       (tx_busy),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives valid for 'hold' clock edges.
    task automatic send(input logic [15:0] w, input int hold, input bit expect_word);
        data_in       = w;
        data_in_valid = 1'b1;
        if (expect_word) begin
            exp_q.push_back(w);
            exp_done++;
        end
        repeat (hold) @(negedge clk);
        data_in_valid = 1'b0;
        data_in       = 16'($urandom);
    endtask

    // Count every tx_done pulse outside reset.
    always @(negedge clk) begin
        if (!rst && tx_done) done_seen <= done_seen + 1;
    end

    // UART receiver model: 20 bit slots per word, sampled mid-bit.
    initial begin : monitor
        bit          pending;
        bit          aborted;
        logic [19:0] smp;
        logic [15:0] got;
        pending = 1'b0;
        forever begin
            if (!pending) @(negedge clk);
            pending = 1'b0;
            if (rst || tx !== 1'b0) continue;
            aborted = 1'b0;
            smp     = '0;
            smp[0]  = tx;
            for (int o = 1; o <= 20 * C; o++) begin
                @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (o % C == C / 2) smp[o / C] = tx;
                if (o == C / 2) chk("busy_in_word", 32'(tx_busy), 32'd1);
            end
            if (aborted) continue;
            chk("framing", 32'({smp[19], smp[10], smp[9], smp[0]}), 32'h0000_000A);
            got = {smp[18:11], smp[8:1]};
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(got), 32'hDEAD_0000);
            end else begin
                chk("word", 32'(got), 32'(exp_q.pop_front()));
            end
            chk("done_at_20_bits", 32'(tx_done), 32'd1);
            chk("busy_low_at_done", 32'(tx_busy), 32'd0);
            @(negedge clk);
            if (!rst) chk("done_one_cycle", 32'(tx_done), 32'd0);
            pending = 1'b1;
        end
    end

    initial begin : stim
        int h;
        int g;
        int n;
        rst           = 1'b1;
        data_in_valid = 1'b0;
        data_in       = 16'h0000;
        @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Directed 0xA55A.
        send(16'hA55A, 1, 1'b1);
        repeat (20 * C + 2) @(negedge clk);

        // data_in changes one cycle after acceptance.
        send(16'hBEEF, 1, 1'b1);
        data_in = 16'h0000;
        repeat (20 * C + 2) @(negedge clk);
        chk("overrun_clean", 32'(overrun), 32'd0);

        // Overrun: second strobe lands at cycle 30 of the first word.
        send(16'h0000, 1, 1'b1);
        repeat (29) @(negedge clk);
        data_in       = 16'hFFFF;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (20 * C - 30 + 4) @(negedge clk);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_idle", 32'(tx_busy), 32'd0);
        repeat (C) @(negedge clk);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        #2 rst = 1'b1;
        #1 chk("overrun_cleared", 32'(overrun), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Held valid: reload in the tx_done cycle, two back-to-back words.
        data_in       = 16'h1234;
        data_in_valid = 1'b1;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h1234);
        exp_done += 2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_done && n < 40 * C);
        chk("held_done_seen", 32'(tx_done), 32'd1);
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (20 * C + 2) @(negedge clk);
        chk("held_no_overrun", 32'(overrun), 32'd0);

        // Reset at cycle 37 of a word aborts it without tx_done.
        send(16'h5A5A, 1, 1'b0);
        repeat (37) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        chk("abort_done", 32'(tx_done), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        send(16'h00FF, 1, 1'b1);
        repeat (20 * C + 2) @(negedge clk);

        // Randomised words, hold lengths and idle gaps (gap 0 = tx_done cycle).
        for (int i = 0; i < 24; i++) begin
            h = $urandom_range(1, 3);
            g = $urandom_range(0, 5);
            send(16'($urandom), h, 1'b1);
            repeat (20 * C - (h - 1) + g) @(negedge clk);
        end
        chk("random_no_overrun", 32'(overrun), 32'd0);

        n = 0;
        while (exp_q.size() != 0 && n < 40 * C) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_seen), 32'(exp_done));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
